// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
// Holds the FSM state encoding, timing defaults and common device commands.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam int unsigned DEF_CLK_HZ         = 50_000_000;
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;      // 100 us at 50 MHz
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750_000;   // 15 ms at 50 MHz

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a PS/2 transmit client and ps2_host_tx.
// The client (master) issues a byte; the transmitter (slave) reports progress.
interface ps2_host_tx_if;
  logic       send_cmd;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output send_cmd, cmd_data, input  busy, done, error);
  modport slave  (input  send_cmd, cmd_data, output busy, done, error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge detect on the synchronized clock; shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_i,
  input  logic dat_i,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic       clk_prev_q, clk_prev_d;

  // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], clk_i};
    dat_sync_d = {dat_sync_q[0], dat_i};
    clk_prev_d = clk_sync_q[1];
  end

  // NOTE: reset to the idle bus level (high) so leaving reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues a start bit,
// shifts data/parity/stop on device clock falls, then checks the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = CLK_HZ / 10_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 1000 * 15
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       send_cmd,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  // INHIBIT lasts INHIBIT_CYCLES-1 cycles; the START cycle completes the low period.
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, dat_s, clk_fall;

  ps2_line_sync u_sync (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .clk_i    (ps2_clk_i),
    .dat_i    (ps2_dat_i),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  state_e           state_q,   state_d;
  logic [7:0]       data_q,    data_d;
  logic             parity_q,  parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             error_q,   error_d;
  logic             clk_oe_q,  clk_oe_d;
  logic             dat_oe_q,  dat_oe_d;
  logic             tmo_state;

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;

    tmo_state = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);
    if (tmo_state) cnt_d = clk_fall ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (send_cmd) begin
          data_d   = cmd_data;
          parity_d = odd_parity(cmd_data);
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        clk_oe_d  = 1'b0;
        bit_cnt_d = '0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          case (bit_cnt_q)
            4'd8:    dat_oe_d = ~parity_q;
            4'd9: begin
              dat_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ACK;
            end
            default: dat_oe_d = ~data_q[bit_cnt_q[2:0]];
          endcase
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!dat_s) begin
            cnt_d   = '0;
            state_d = WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Device went silent: abandon the frame and free both lines.
    if (tmo_state && !clk_fall && !done_d && cnt_q == TMO_LAST) begin
      error_d  = 1'b1;
      busy_d   = 1'b0;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      cnt_d    = '0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// a scoreboard monitor checks each done/error pulse against queued expectations.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned TB_INHIBIT = DEF_INHIBIT_CYCLES;
  localparam int unsigned TB_TIMEOUT = 2000;
  localparam int unsigned HALF       = 20;

  typedef enum int {DEV_ACK, DEV_NACK, DEV_STALL, DEV_HALT} dev_mode_e;
  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ok;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic dev_clk  = 1'b1;
  logic dev_dat  = 1'b1;
  logic ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;

  ps2_host_tx_if cmd_if ();

  always #10 CLOCK_50 = ~CLOCK_50;

  // Open-drain lines: either side pulling low wins.
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .send_cmd   (cmd_if.send_cmd),
    .cmd_data   (cmd_if.cmd_data),
    .busy       (cmd_if.busy),
    .done       (cmd_if.done),
    .error      (cmd_if.error),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pulse_cnt = 0;
  int err_cyc   = 0;
  int last_fall_cyc = 0;
  logic [9:0] dev_bits = '0;
  logic chk_oe_next = 1'b0;
  logic prev_busy   = 1'b0;
  exp_t exp_q[$];
  exp_t e;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: every done/error pulse consumes one expected entry.
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      chk_oe_next = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      if (chk_oe_next) begin
        check("err_oe_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        chk_oe_next = 1'b0;
      end
      if (prev_busy && !cmd_if.busy) check("busy_fall_with_pulse", cmd_if.done | cmd_if.error, 1);
      if (cmd_if.done || cmd_if.error) begin
        pulse_cnt++;
        check("pulse_exclusive", cmd_if.done & cmd_if.error, 0);
        check("busy_low_at_pulse", cmd_if.busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", cmd_if.done, e.ok);
          if (cmd_if.done && e.ok) begin
            check("wire_byte", dev_bits[7:0], e.data);
            check("wire_parity", dev_bits[8], e.parity);
            check("wire_stop", dev_bits[9], 1);
          end
          if (cmd_if.error) begin
            err_cyc     = cyc;
            chk_oe_next = 1'b1;
          end
        end
      end
      prev_busy = cmd_if.busy;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b, input logic par, input logic ok, input bit accept);
    @(negedge CLOCK_50);
    cmd_if.send_cmd = 1'b1;
    cmd_if.cmd_data = b;
    if (accept) exp_q.push_back('{data: b, parity: par, ok: ok});
    @(negedge CLOCK_50);
    cmd_if.send_cmd = 1'b0;
  endtask

  // Device side of one frame: measure the inhibit, then generate clock pulses.
  task automatic device_frame(input dev_mode_e mode);
    int   n;
    logic last_dat;
    n = 0;
    last_dat = 1'b0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("inhibit_started", ps2_clk_oe, 1);
    n = 0;
    while (ps2_clk_oe && n < 2 * TB_INHIBIT) begin
      last_dat = ps2_dat_oe;
      @(negedge CLOCK_50);
      n++;
    end
    check("inhibit_length", n, TB_INHIBIT);
    check("start_bit_last_inhibit", last_dat, 1);
    check("start_bit_held", ps2_dat_oe, 1);
    wait_cycles(10);
    for (int i = 0; i < 11; i++) begin
      if (mode == DEV_STALL && i == 4) return;
      if (mode == DEV_ACK && i == 10) dev_dat = 1'b0;
      wait_cycles(2);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(HALF);
      if (mode == DEV_HALT && i == 5) return;
      dev_clk = 1'b1;
      wait_cycles(HALF);
      if (i < 10) dev_bits[i] = ps2_dat_i;
      if (i == 9) check("busy_mid_frame", cmd_if.busy, 1);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int prev, input int bound, input string name);
    int n;
    n = 0;
    while (pulse_cnt == prev && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(name, pulse_cnt, prev + 1);
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input dev_mode_e mode,
                           input logic ok);
    int p;
    p = pulse_cnt;
    send(b, par, ok, 1'b1);
    device_frame(mode);
    wait_pulse(p, 500, "frame_end_pulse");
  endtask

  initial begin
    #(90_000 * 20);
    $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int  p;
    logic saw_clk_oe;
    cmd_if.send_cmd = 1'b0;
    cmd_if.cmd_data = '0;

    wait_cycles(3);
    check("reset_busy",   cmd_if.busy,  0);
    check("reset_done",   cmd_if.done,  0);
    check("reset_error",  cmd_if.error, 0);
    check("reset_clk_oe", ps2_clk_oe,   0);
    check("reset_dat_oe", ps2_dat_oe,   0);
    resetn = 1'b1;
    wait_cycles(5);

    // Normal frames: ED has six ones (parity 1), 00 -> parity 1, 01 -> parity 0.
    run_frame(CMD_SET_LEDS, 1'b1, DEV_ACK, 1'b1);
    run_frame(8'h00,        1'b1, DEV_ACK, 1'b1);
    run_frame(8'h01,        1'b0, DEV_ACK, 1'b1);

    // Device never pulls data low at the ACK edge.
    run_frame(CMD_ENABLE, 1'b0, DEV_NACK, 1'b0);

    // Device stops clocking after four bits.
    p = pulse_cnt;
    send(CMD_SET_LEDS, 1'b1, 1'b0, 1'b1);
    device_frame(DEV_STALL);
    wait_pulse(p, TB_TIMEOUT + 100, "timeout_pulse");
    // Fall crosses the 2-flop sync, then the counter runs TIMEOUT cycles to a registered error.
    check("timeout_latency", err_cyc - last_fall_cyc, TB_TIMEOUT + 3);

    // A second request while busy must be dropped.
    p = pulse_cnt;
    send(CMD_RESET, 1'b1, 1'b1, 1'b1);
    fork
      device_frame(DEV_ACK);
      begin
        wait_cycles(TB_INHIBIT + 200);
        send(CMD_ENABLE, 1'b0, 1'b1, 1'b0);
      end
    join
    wait_pulse(p, 500, "busy_frame_end");
    saw_clk_oe = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe) saw_clk_oe = 1'b1;
    end
    check("no_second_frame", saw_clk_oe, 0);

    // Reset while the host is shifting bit 5.
    send(CMD_SET_LEDS, 1'b1, 1'b1, 1'b1);
    device_frame(DEV_HALT);
    #3 resetn = 1'b0;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe,  0);
    check("rst_mid_dat_oe", ps2_dat_oe,  0);
    check("rst_mid_busy",   cmd_if.busy, 0);
    exp_q.delete();
    wait_cycles(3);
    dev_clk = 1'b1;
    wait_cycles(2);
    resetn = 1'b1;
    wait_cycles(5);
    check("post_rst_idle_busy", cmd_if.busy, 0);
    run_frame(CMD_SET_LEDS, 1'b1, DEV_ACK, 1'b1);

    wait_cycles(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
